// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx -- 8N1 asynchronous serial receiver with a runtime bit period.
//
// The serial line passes through a synchronizer chain. A falling edge on the
// synchronized line, seen while idle, starts a frame. The bit period in clocks
// is latched from baud_div at that edge and applies to the whole frame.
// The start bit is re-checked half a period later, then eight data bits
// (LSB first) are sampled one period apart, and the stop bit one period
// after that. A good stop bit publishes the byte with a one-cycle rx_done.
// A bad stop bit gives a one-cycle rx_err, and the receiver then waits for
// the line to go high again before it looks for another start bit.
//
// Parameters
//   C_SYNC_STAGES : flops in the rx_din_i synchronizer (values below 2 use 2)
//
// Ports
//   clock_i   in   1  sole clock, rising edge
//   reset_i   in   1  synchronous, active-high reset
//   baud_div  in  12  clocks per bit period, sampled at each start edge
//   rx_din_i  in   1  asynchronous serial line, idle high
//   rx_data_o out  8  last correctly received byte
//   rx_done   out  1  one-cycle pulse when rx_data_o has been updated
//   rx_ing    out  1  high while a frame is being received
//   rx_err    out  1  one-cycle pulse on a framing error (stop bit low)
// ----------------------------------------------------------------------------
module uart_rx #(
  parameter int C_SYNC_STAGES = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [11:0] baud_div,
  input  logic        rx_din_i,
  output logic [7:0]  rx_data_o,
  output logic        rx_done,
  output logic        rx_ing,
  output logic        rx_err
);

  localparam int SYNC_W = (C_SYNC_STAGES < 2) ? 2 : C_SYNC_STAGES;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t            state;
  logic [SYNC_W-1:0] sync_q;
  logic              s_cur;
  logic              s_prev;
  logic [11:0]       dl;
  logic [11:0]       cnt;
  logic [11:0]       half_m1;
  logic [11:0]       full_m1;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;

  // Periods shorter than 4 clocks leave no room for a mid-bit sample, so the
  // latched period saturates at 4.
  function automatic logic [11:0] clamp_period(input logic [11:0] d);
    return (d < 12'd4) ? 12'd4 : d;
  endfunction

  assign s_cur = sync_q[SYNC_W-1];

  // The counter reads k-1 in the k-th cycle after the edge (or after the
  // previous sample), so sample points compare against period-1 / half-1.
  assign half_m1 = {1'b0, dl[11:1]} - 12'd1;
  assign full_m1 = dl - 12'd1;

  // Synchronizer and previous-sample register reset to the idle level so the
  // first cycles after reset never look like a start edge.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync_q <= '1;
      s_prev <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_W-2:0], rx_din_i};
      s_prev <= s_cur;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state     <= IDLE;
      dl        <= 12'd0;
      cnt       <= 12'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'd0;
      rx_data_o <= 8'd0;
      rx_done   <= 1'b0;
      rx_ing    <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      rx_err  <= 1'b0;

      case (state)
        IDLE: begin
          // Also reached in the rx_done cycle, so a start bit that follows
          // the stop bit with no idle gap is still caught.
          if (!s_cur && s_prev) begin
            state  <= START;
            dl     <= clamp_period(baud_div);
            cnt    <= 12'd0;
            rx_ing <= 1'b1;
          end
        end

        START: begin
          if (cnt == half_m1) begin
            cnt <= 12'd0;
            if (!s_cur) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              // Line went back high before mid start bit: a glitch.
              state  <= IDLE;
              rx_ing <= 1'b0;
            end
          end else begin
            cnt <= cnt + 12'd1;
          end
        end

        DATA: begin
          if (cnt == full_m1) begin
            cnt   <= 12'd0;
            // Shift in at the top so the first (LSB) sample ends in bit 0.
            shreg <= {s_cur, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 12'd1;
          end
        end

        STOP: begin
          if (cnt == full_m1) begin
            cnt    <= 12'd0;
            rx_ing <= 1'b0;
            if (s_cur) begin
              rx_data_o <= shreg;
              rx_done   <= 1'b1;
              state     <= IDLE;
            end else begin
              rx_err <= 1'b1;
              state  <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 12'd1;
          end
        end

        WAIT_IDLE: begin
          // A held-low line (break) stays here, so it reports one error only.
          if (s_cur) begin
            state <= IDLE;
          end
        end

        default: begin
          state  <= IDLE;
          rx_ing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
// Stimulus tasks push the expected pulse (kind, byte, cycle) into a queue
// when they start a frame; a monitor on the falling clock edge pops and
// compares whenever rx_done or rx_err is seen, and flags overdue entries.
// ----------------------------------------------------------------------------
module tb_uart_rx;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [11:0] baud_div = 12'd87;
  logic        rx_din_i = 1'b1;
  logic [7:0]  rx_data_o;
  logic        rx_done;
  logic        rx_ing;
  logic        rx_err;

  uart_rx #(.C_SYNC_STAGES(2)) dut (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .baud_div (baud_div),
    .rx_din_i (rx_din_i),
    .rx_data_o(rx_data_o),
    .rx_done  (rx_done),
    .rx_ing   (rx_ing),
    .rx_err   (rx_err)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  int         activity = 0;
  logic [7:0] last_data = 8'h00;

  always @(posedge clock_i) cyc <= cyc + 1;

  always @(negedge clock_i) begin
    if (rx_done || rx_err || rx_ing) activity <= activity + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clock_i) begin
    if (!reset_i) begin
      if (q.size() > 0 && cyc > q[0].due) begin
        mon_e = q.pop_front();
        n_vec++;
        n_bad++;
        $display("FAIL missing_pulse: nothing by cycle %0d, expected err=%0b data=%02h at cycle %0d",
                 cyc, mon_e.is_err, mon_e.data, mon_e.due);
      end
      if (rx_done || rx_err) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b data=%02h at cycle %0d, none expected",
                   rx_done, rx_err, rx_data_o, cyc);
        end else begin
          mon_e = q.pop_front();
          if (rx_done !== !mon_e.is_err || rx_err !== mon_e.is_err ||
              rx_data_o !== mon_e.data || cyc != mon_e.due) begin
            n_bad++;
            $display("FAIL pulse: done=%0b err=%0b data=%02h cycle=%0d, expected done=%0b err=%0b data=%02h cycle=%0d",
                     rx_done, rx_err, rx_data_o, cyc, !mon_e.is_err, mon_e.is_err, mon_e.data, mon_e.due);
          end
        end
      end
    end
  end

  // Sends one frame starting at the current falling edge; returns on the
  // falling edge that ends the stop bit (line left at the stop level).
  task automatic send(input logic [7:0] b, input logic stop, input int per);
    exp_t       e;
    bit         ing_ok;
    logic [9:0] frame;
    ing_ok   = 1'b1;
    frame    = {stop, b, 1'b0};
    e.is_err = !stop;
    e.data   = stop ? b : last_data;
    // 2 synchronizer cycles, half period to start check, 9 periods, +1.
    e.due    = cyc + 2 + per / 2 + 9 * per + 1;
    if (stop) last_data = b;
    q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      rx_din_i = frame[i];
      repeat (per / 2) @(negedge clock_i);
      if (rx_ing !== 1'b1) ing_ok = 1'b0;
      repeat (per - per / 2) @(negedge clock_i);
    end
    check($sformatf("rx_ing_during_%02h", b), {31'd0, ing_ok}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int act0;
    logic [7:0] part;
    reset_i  = 1'b1;
    rx_din_i = 1'b1;
    baud_div = 12'd87;
    repeat (3) @(negedge clock_i);
    reset_i = 1'b0;

    // Reset state and quiet idle line.
    check("reset_rx_data_o", {24'd0, rx_data_o}, 32'h00);
    check("reset_rx_done", {31'd0, rx_done}, 32'd0);
    check("reset_rx_ing", {31'd0, rx_ing}, 32'd0);
    check("reset_rx_err", {31'd0, rx_err}, 32'd0);
    act0 = activity;
    repeat (2000) @(negedge clock_i);
    check("idle_quiet_activity", activity - act0, 32'd0);

    // Single frame.
    send(8'hA5, 1'b1, 87);
    repeat (20) @(negedge clock_i);

    // Back-to-back frames; baud_div changes in the middle of 0xFF.
    send(8'h00, 1'b1, 87);
    fork
      send(8'hFF, 1'b1, 87);
      begin
        repeat (300) @(negedge clock_i);
        baud_div = 12'd16;
      end
    join
    send(8'h3C, 1'b1, 16);
    repeat (20) @(negedge clock_i);

    // Framing error followed by a long break, then a good frame.
    baud_div = 12'd87;
    send(8'h5A, 1'b0, 87);
    repeat (2000) @(negedge clock_i);
    rx_din_i = 1'b1;
    repeat (50) @(negedge clock_i);
    check("data_kept_after_err", {24'd0, rx_data_o}, 32'h3C);
    send(8'h11, 1'b1, 87);
    repeat (20) @(negedge clock_i);

    // 20-cycle glitch: receiver starts, then abandons at the start check.
    rx_din_i = 1'b0;
    repeat (20) @(negedge clock_i);
    rx_din_i = 1'b1;
    check("glitch_rx_ing_rises", {31'd0, rx_ing}, 32'd1);
    repeat (40) @(negedge clock_i);
    check("glitch_rx_ing_falls", {31'd0, rx_ing}, 32'd0);
    repeat (20) @(negedge clock_i);
    send(8'h96, 1'b1, 87);
    repeat (20) @(negedge clock_i);

    // Reset in the middle of data bit 4 of 0xE7.
    part = 8'hE7;
    rx_din_i = 1'b0;
    repeat (87) @(negedge clock_i);
    for (int i = 0; i < 4; i++) begin
      rx_din_i = part[i];
      repeat (87) @(negedge clock_i);
    end
    rx_din_i = part[4];
    repeat (40) @(negedge clock_i);
    reset_i  = 1'b1;
    rx_din_i = 1'b1;
    repeat (3) @(negedge clock_i);
    reset_i   = 1'b0;
    last_data = 8'h00;
    check("midframe_reset_rx_ing", {31'd0, rx_ing}, 32'd0);
    check("midframe_reset_rx_data_o", {24'd0, rx_data_o}, 32'h00);
    repeat (100) @(negedge clock_i);
    send(8'hC3, 1'b1, 87);
    repeat (20) @(negedge clock_i);

    check("scoreboard_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 The block SHALL have parameter C_SYNC_STAGES, default 2: number of flops in the rx_din_i synchronizer chain (minimum 2).
- REQ-002 The block SHALL have port clock_i  input  1  sole clock; all logic on its rising edge.
- REQ-003 The block SHALL have port reset_i  input  1  reset, synchronous, active-high.
- REQ-004 The block SHALL have port baud_div  input  12  clocks per bit period (D).
- REQ-005 The block SHALL have port rx_din_i  input  1  asynchronous serial line; idle high.
- REQ-006 The block SHALL have port rx_data_o  output  8  last correctly received byte.
- REQ-007 The block SHALL have port rx_done  output  1  one-cycle pulse when rx_data_o has been updated.
- REQ-008 The block SHALL have port rx_ing  output  1  high while a frame is being received.
- REQ-009 The block SHALL have port rx_err  output  1  one-cycle pulse on a framing error.

Function
- REQ-010 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- REQ-011 rx_din_i SHALL pass through C_SYNC_STAGES flops; all decisions use the synchronized value S.
- REQ-012 States SHALL be IDLE, START, DATA, STOP and WAIT_IDLE.
- REQ-013 In IDLE, the cycle where S is 0 and previous S was 1 (edge cycle E) SHALL move the FSM to START, latch baud_div into an internal register Dl, and clear the cycle counter.
- REQ-014 Dl SHALL be the effective period for the whole frame; baud_div changes mid-frame SHALL be ignored; a latched value below 4 SHALL be treated as 4.
- REQ-015 The start-bit check SHALL occur at cycle E + floor(Dl/2): S=0 -> DATA; S=1 -> IDLE (false start, no pulses).
- REQ-016 Each data bit SHALL be sampled Dl cycles after the previous sample, for 8 samples, shifting into bit 7 of a shift register so that the first sample lands in bit 0.
- REQ-017 After the 8th data sample the FSM SHALL enter STOP; the stop sample SHALL occur Dl cycles later.
- REQ-018 On a stop sample of 1: rx_data_o SHALL load the shift register and rx_done SHALL pulse high for exactly one cycle, the cycle after the stop sample; the FSM SHALL return to IDLE in that cycle.
- REQ-019 Latency from E to rx_done SHALL be floor(Dl/2) + 9*Dl + 1 cycles (827 for D=87).
- REQ-020 On a stop sample of 0: rx_err SHALL pulse one cycle (same timing as rx_done), rx_data_o SHALL remain unchanged, rx_done SHALL stay low, and the FSM SHALL enter WAIT_IDLE.
- REQ-021 WAIT_IDLE SHALL return to IDLE on the first cycle with S=1; a continuous low (break) SHALL produce exactly one rx_err and no further frames.
- REQ-022 rx_ing SHALL be high in START, DATA and STOP, and low in IDLE and WAIT_IDLE.
- REQ-023 rx_done and rx_err SHALL never be high in the same cycle.
- REQ-024 A falling edge during the rx_done cycle SHALL be detected normally, so back-to-back frames with no idle gap are received.
- REQ-025 The cycle counter SHALL be 12 bits wide and SHALL not wrap within a bit period for any Dl up to 4095.

Reset
- REQ-026 When reset_i is high at a clock edge, the FSM SHALL go to IDLE.
- REQ-027 Reset SHALL clear rx_data_o to 0x00; rx_done, rx_ing and rx_err to 0; and all counters, the shift register and Dl to 0.
- REQ-028 Reset SHALL set the synchronizer flops and the previous-S register to 1, so no false edge is seen after reset.
- REQ-029 Reset asserted mid-frame SHALL abort the frame with no rx_done or rx_err pulse.
- REQ-030 After a mid-frame reset the block SHALL resynchronize on the next falling edge that follows a high level.

Verification
- REQ-031 Reset held 3 cycles, line high -> rx_data_o=0x00; rx_done, rx_ing and rx_err low; all remain quiet for 2000 cycles.
- REQ-032 D=87, send 0xA5 -> one rx_done pulse 827 cycles after the synchronized edge, rx_data_o=0xA5, rx_ing high throughout the frame, no rx_err.
- REQ-033 D=87, send 0x00 then 0xFF with no gap, then D=16 and send 0x3C -> rx_done pulses with 0x00, 0xFF and 0x3C; baud_div changed mid-frame does not corrupt the frame in progress.
- REQ-034 D=87, send 0x5A with the stop bit 0, then hold the line low 2000 cycles -> exactly one rx_err pulse, no rx_done, rx_data_o keeps its prior value; a following 0x11 frame is received correctly.
- REQ-035 D=87, 20-cycle low glitch on the line -> rx_ing rises then falls at the start check, no pulses, next frame is received correctly.
- REQ-036 D=87, reset asserted during data bit 4 -> no pulses; a frame started 100 cycles after reset release yields the correct byte.
